// File: rtl/tetris_pkg.sv
// tetris_pkg: shared geometry, move encoding and spawn masks for the 4x8 falling-block core.
package tetris_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 4;
  typedef enum logic [1:0] {MV_NONE, MV_LEFT, MV_RIGHT, MV_DROP} move_e;
  localparam logic [31:0] SPAWN [4] = '{32'h66, 32'h06, 32'h26, 32'h02};
  localparam logic [31:0] COL0 = 32'h1111_1111;
  localparam logic [31:0] COL3 = 32'h8888_8888;
  localparam logic [31:0] ROW7 = 32'hF000_0000;
  function automatic logic blocked_down(input logic [31:0] p, input logic [31:0] lk);
    return (|(p & ROW7)) || (|((p << COLS) & lk));
  endfunction
endpackage

// File: rtl/tetris_line_clear.sv
// tetris_line_clear: removes full rows and compacts the remaining rows toward the bottom.
module tetris_line_clear
  import tetris_pkg::*;
(
  input  logic [31:0] board,
  output logic [31:0] cleared,
  output logic [3:0]  count
);
  // scanning bottom-up, each kept row drops by the number of full rows found below it
  always_comb begin
    cleared = '0;
    count = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (&board[4*r +: 4]) count = count + 4'd1;
      else cleared[4*(r + int'(count)) +: 4] = board[4*r +: 4];
  end
endmodule

// File: rtl/tetris_top.sv
// tetris_top: 4x8 falling-block game core; define TETRIS_PIECE_LFSR_EN for LFSR-chosen pieces
// instead of the fixed O, I2, L, DOT cycle.
module tetris_top
  import tetris_pkg::*;
#(
  parameter int DROP_DIV = 1
) (
  input  logic        in_clka,
  input  logic        in_restart,
  input  logic [1:0]  in_move,
  output logic [31:0] board_out
);
  logic [31:0] locked_q, locked_d, piece_q, piece_d, board_q, board_d;
  logic [31:0] mv_p, merged, clr_board;
  logic [1:0]  idx_q, idx_d, idx_n;
  logic [3:0]  cnt_q, cnt_d, cnt_g, clr_cnt;
  logic        over_q, over_d, lock;
  move_e       mv;
  assign mv = move_e'(in_move);
  always_comb begin
    mv_p = piece_q;
    lock = 1'b0;
    cnt_g = cnt_q;
    if (!over_q) begin
      if (mv == MV_LEFT && !(|(mv_p & COL0)) && !(|((mv_p >> 1) & locked_q))) mv_p = mv_p >> 1;
      if (mv == MV_RIGHT && !(|(mv_p & COL3)) && !(|((mv_p << 1) & locked_q))) mv_p = mv_p << 1;
      if (mv == MV_DROP) begin
        for (int i = 0; i < ROWS; i++) mv_p = blocked_down(mv_p, locked_q) ? mv_p : mv_p << COLS;
        lock = 1'b1;
      end else begin
        cnt_g = (cnt_q == 4'(DROP_DIV - 1)) ? 4'd0 : cnt_q + 4'd1;
        if (cnt_g == 4'd0) begin
          lock = blocked_down(mv_p, locked_q);
          mv_p = lock ? mv_p : mv_p << COLS;
        end
      end
    end
  end
  assign merged = locked_q | mv_p;
  tetris_line_clear u_clear (.board(merged), .cleared(clr_board), .count(clr_cnt));
`ifdef TETRIS_PIECE_LFSR_EN
  logic [3:0] lfsr_q, lfsr_d;
  assign lfsr_d = lock ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;
  assign idx_n = lfsr_d[1:0];
  always_ff @(posedge in_clka) lfsr_q <= in_restart ? 4'b1001 : lfsr_d;
`else
  assign idx_n = idx_q + 2'd1;
`endif
  always_comb begin
    locked_d = locked_q;
    piece_d = mv_p;
    idx_d = idx_q;
    cnt_d = cnt_g;
    over_d = over_q;
    if (lock) begin
      locked_d = (clr_cnt != 4'd0) ? clr_board : merged;
      idx_d = idx_n;
      piece_d = SPAWN[idx_n];
      cnt_d = 4'd0;
      over_d = |(SPAWN[idx_n] & locked_d);
    end
    board_d = locked_d | piece_d;
  end
  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      locked_q <= '0;
      piece_q <= SPAWN[0];
      idx_q <= '0;
      cnt_q <= '0;
      over_q <= 1'b0;
      board_q <= 32'h0000_0066;
    end else begin
      locked_q <= locked_d;
      piece_q <= piece_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      over_q <= over_d;
      board_q <= board_d;
    end
  end
  assign board_out = board_q;
endmodule

// File: tb/tb_tetris_top.sv
// tb_tetris_top: directed vector table, game-over sequence and random play against a cell-grid model.
module tb_tetris_top;
  logic        clk = 1'b0;
  logic        in_restart = 1'b1;
  logic [1:0]  in_move = 2'b00;
  logic [31:0] board_out;
  int          passed = 0;
  int          total = 0;

  tetris_top dut (.in_clka(clk), .in_restart(in_restart), .in_move(in_move), .board_out(board_out));

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [1:0]  mv;
    logic [31:0] exp;
  } vec_t;

  bit mlk [8][4];
  bit mpc [8][4];
  int midx;
  bit mover;
  int spawn_rows [4][2] = '{'{6, 6}, '{6, 0}, '{6, 2}, '{2, 0}};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: board_out=%h expected=%h", name, got, exp);
  endtask

  task automatic cyc(input bit r, input logic [1:0] m);
    in_restart = r;
    in_move = m;
    @(posedge clk);
    #1;
  endtask

  function automatic bit fits(input int dr, input int dc);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (mpc[r][c]) begin
          if (r + dr > 7 || c + dc < 0 || c + dc > 3) return 1'b0;
          if (mlk[r + dr][c + dc]) return 1'b0;
        end
    return 1'b1;
  endfunction

  task automatic m_shift(input int dr, input int dc);
    bit t [8][4] = '{default: 1'b0};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        if (mpc[r][c]) t[r + dr][c + dc] = 1'b1;
    mpc = t;
  endtask

  task automatic m_spawn();
    mover = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) begin
        mpc[r][c] = (r < 2) ? spawn_rows[midx][r][c] : 1'b0;
        if (mpc[r][c] && mlk[r][c]) mover = 1'b1;
      end
  endtask

  task automatic m_lock();
    bit nl [8][4] = '{default: 1'b0};
    int w = 7;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) mlk[r][c] |= mpc[r][c];
    for (int r = 7; r >= 0; r--)
      if (!(mlk[r][0] && mlk[r][1] && mlk[r][2] && mlk[r][3])) begin
        nl[w] = mlk[r];
        w--;
      end
    mlk = nl;
    midx = (midx + 1) % 4;
    m_spawn();
  endtask

  task automatic m_reset();
    mlk = '{default: '{default: 1'b0}};
    midx = 0;
    m_spawn();
  endtask

  task automatic m_step(input logic [1:0] m);
    if (mover) return;
    if (m == 2'b01 && fits(0, -1)) m_shift(0, -1);
    if (m == 2'b10 && fits(0, 1)) m_shift(0, 1);
    if (m == 2'b11) begin
      while (fits(1, 0)) m_shift(1, 0);
      m_lock();
    end else if (fits(1, 0)) m_shift(1, 0);
    else m_lock();
  endtask

  function automatic logic [31:0] m_board();
    logic [31:0] b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) b[r*4 + c] = mlk[r][c] | mpc[r][c];
    return b;
  endfunction

  initial begin
    vec_t vt[$];
    logic [31:0] frozen;
    logic [1:0]  m;
    bit          r;
    vt = '{
      '{1, 2'b00, 32'h0000_0066}, '{0, 2'b00, 32'h0000_0660},
      '{1, 2'b00, 32'h0000_0066}, '{0, 2'b01, 32'h0000_0330}, '{0, 2'b01, 32'h0000_3300},
      '{0, 2'b01, 32'h0003_3000},
      '{1, 2'b00, 32'h0000_0066}, '{0, 2'b00, 32'h0000_0660}, '{0, 2'b00, 32'h0000_6600},
      '{0, 2'b00, 32'h0006_6000}, '{0, 2'b00, 32'h0066_0000}, '{0, 2'b00, 32'h0660_0000},
      '{0, 2'b00, 32'h6600_0000}, '{0, 2'b00, 32'h6600_0006},
      '{1, 2'b00, 32'h0000_0066}, '{0, 2'b11, 32'h6600_0006},
      '{1, 2'b00, 32'h0000_0066}, '{0, 2'b01, 32'h0000_0330}, '{0, 2'b00, 32'h0000_3300},
      '{0, 2'b00, 32'h0003_3000}, '{0, 2'b00, 32'h0033_0000}, '{0, 2'b00, 32'h0330_0000},
      '{0, 2'b00, 32'h3300_0000}, '{0, 2'b00, 32'h3300_0006}, '{0, 2'b10, 32'h3300_00C0},
      '{0, 2'b00, 32'h3300_0C00}, '{0, 2'b00, 32'h3300_C000}, '{0, 2'b00, 32'h330C_0000},
      '{0, 2'b00, 32'h33C0_0000}, '{0, 2'b00, 32'h3F00_0000}, '{0, 2'b00, 32'hF300_0000},
      '{0, 2'b00, 32'h3000_0026}
    };
    foreach (vt[i]) begin
      cyc(vt[i].rst, vt[i].mv);
      chk($sformatf("vec%0d", i), board_out, vt[i].exp);
    end

    // stack hard drops until the spawn collides, then the board must freeze
    m_reset();
    cyc(1, 2'b00);
    chk("go_reset", board_out, m_board());
    for (int i = 0; i < 40 && !mover; i++) begin
      m_step(2'b11);
      cyc(0, 2'b11);
      chk($sformatf("go_drop%0d", i), board_out, m_board());
    end
    if (!mover) begin
      total++;
      $display("FAIL go_timeout: game over not reached, expected within 40 drops");
    end
    frozen = m_board();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 2'(i % 4));
      chk($sformatf("go_frozen%0d", i), board_out, frozen);
    end
    cyc(1, 2'b11);
    chk("go_restart", board_out, 32'h0000_0066);

    m_reset();
    cyc(1, 2'b00);
    chk("rand_reset", board_out, m_board());
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 39) == 0);
      m = 2'($urandom_range(0, 3));
      if (r) m_reset();
      else m_step(m);
      cyc(r, m);
      chk($sformatf("rand%0d", i), board_out, m_board());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tetris_top.md
Name: tetris_top

Overview:
- Single-clock core of a 4-column x 8-row falling-block game.
- Each cycle it applies one player move, applies gravity, locks the piece on landing, clears full rows and spawns the next piece.
- The composite board (locked cells OR active piece) is driven on a 32-bit output for the display/pad ring.
- Top level of the chip; no other logic sits between it and the pins.

Parameters:
DROP_DIV, 1, gravity period in clock cycles (1 = piece descends every cycle); legal range 1..15.

Ports:
in_clka  input  1  sole clock; all state updates on its rising edge.
in_restart  input  1  synchronous active-high reset / game restart.
in_move  input  2  player command sampled each cycle: 00 none, 01 left, 10 right, 11 hard drop.
board_out  output  32  registered composite board; bit index = row*4 + col; row 0 = top, col 0 = left.

Behaviour:
- Cell geometry: row r occupies bits [4r+3:4r]. Moving left is toward col 0, i.e. a 1-bit right shift of the piece mask; moving down is a 4-bit left shift.
- State: locked[31:0], piece[31:0] (active cells, board coordinates), piece index, gravity counter, game_over flag, board_out register.
- Reset (in_restart=1 at clock edge):
  - locked=0, piece index=0, gravity counter=0, game_over=0.
  - piece = spawn mask of O.
  - board_out = 0x00000066.
  - Reset overrides all other activity, including mid-game and during game over.
- Spawn masks (rows 0-1, cols 1-2), fixed order O, I2, L, DOT, repeating:
  - O = 0x66
  - I2 = 0x06
  - L = 0x26
  - DOT = 0x02
- Per-cycle order when not game_over:
  1. Horizontal move (01 or 10). Applied only if no piece cell is in the edge column (col 0 for left, col 3 for right) and the shifted mask does not overlap locked. Otherwise the move is ignored.
  2. Hard drop (11). The piece moves to its lowest legal position (no cell past row 7, no overlap with locked) and locks in the same cycle. Gravity is skipped that cycle.
  3. Gravity. The counter increments each cycle; when it equals DROP_DIV-1 it wraps to 0 and a down step is attempted on the post-move piece. If the piece has a cell in row 7, or the shifted mask overlaps locked, the piece locks instead.
- Lock sequence, all in one cycle:
  - locked |= piece.
  - Every row equal to 4'hF is removed; rows above compact downward; vacated top rows become 0. Multiple rows may clear at once.
  - Piece index advances mod 4 and the next spawn mask is loaded.
  - Gravity counter resets to 0.
- Game over: if the new spawn mask overlaps the post-clear locked board, game_over=1. Once set:
  - board_out = locked | spawn mask, frozen.
  - in_move and gravity are ignored until in_restart.
- board_out is updated every cycle to next_locked | next_piece; one cycle latency from in_move to board_out.
- in_move is sampled every cycle with no handshake and no edge detection; holding 01 shifts one column per cycle.

Optional Feature:
- Macro TETRIS_PIECE_LFSR_EN.
- Defined:
  - A 4-bit maximal LFSR (taps x^4+x^3+1) is seeded to 4'b1001 on reset and steps once per lock.
  - The next piece = lfsr[1:0] (0=O, 1=I2, 2=L, 3=DOT).
  - The first piece after reset is still O.
- Undefined: the fixed cyclic order above applies.

Decomposition:
- Package tetris_pkg:
  - ROWS=8, COLS=4.
  - Move encoding enum {MV_NONE, MV_LEFT, MV_RIGHT, MV_DROP}.
  - Spawn-mask constant array indexed by piece id.
  - Column edge masks: COL0 = 0x11111111, COL3 = 0x88888888.
  - ROW7 mask = 0xF0000000.
- One sub-module, tetris_line_clear: combinational; input 32-bit board, output compacted board and a 4-bit cleared-row count.

Test Plan:
- Reset then one cycle with in_move=00 -> board_out 0x00000066, then 0x00000660.
- Reset; in_move=01 for one cycle -> 0x00000330. Hold 01 for 2 more cycles -> stays in col 0 (0x00033000 after 3 cycles).
- Reset, in_move=00 for 7 cycles -> 6th cycle 0x66000000. 7th cycle locks and spawns I2 -> 0x66000006.
- Reset, in_move=11 -> next cycle board_out 0x66000006.
- Row clear:
  - Reset, 01 once, then 00 until lock -> locked 0x33000000.
  - Then 10 once and 00 until lock -> row 7 fills and clears.
  - Result board_out 0x30000026.
- Stack pieces via repeated 11 until spawn overlaps -> board_out frozen for 5+ cycles under any in_move. Assert in_restart -> 0x00000066 next cycle.
